// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Holds one decoded instruction for the execute stage, resolves its source
// operands against the EX/MEM and MEM/WB results, and requests a decode stall
// when a load in EX feeds the instruction currently in decode.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        id_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,

    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [3:0]  alu_ctrl_i,
    input  logic        alu_src_i,
    input  logic        reg_dst_i,
    input  logic        reg_write_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        mem_to_reg_i,

    input  logic        exmem_reg_write_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [31:0] exmem_result_i,
    input  logic        memwb_reg_write_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic [31:0] memwb_result_i,

    output logic [31:0] src1_o,
    output logic [31:0] src2_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  wr_addr_o,
    output logic        reg_write_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        mem_to_reg_o,
    output logic        ex_valid_o,
    output logic        hazard_o
);

    // Stage state
    logic        valid_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  rs_addr_q;
    logic [4:0]  rt_addr_q;
    logic [4:0]  wr_addr_q;
    logic [3:0]  alu_ctrl_q;
    logic        alu_src_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        mem_to_reg_q;

    // Forwarding decode and resolved operands
    logic        exmem_hit_rs;
    logic        exmem_hit_rt;
    logic        memwb_hit_rs;
    logic        memwb_hit_rt;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Hazard decode
    logic        load_in_ex;
    logic        dep_rs;
    logic        dep_rt;
    logic        hazard;

    // Destination select for the incoming instruction
    logic [4:0]  wr_addr_next;

    // Match each forwarding source against the stored source registers; r0 never matches
    always_comb begin
        exmem_hit_rs = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_q);
        exmem_hit_rt = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rt_addr_q);
        memwb_hit_rs = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_q);
        memwb_hit_rt = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rt_addr_q);
    end

    // Operand muxes: the younger EX/MEM result wins over MEM/WB
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        if (exmem_hit_rs) begin
            fwd_rs = exmem_result_i;
        end else if (memwb_hit_rs) begin
            fwd_rs = memwb_result_i;
        end
        if (exmem_hit_rt) begin
            fwd_rt = exmem_result_i;
        end else if (memwb_hit_rt) begin
            fwd_rt = memwb_result_i;
        end
    end

    // Load-use detection: a valid load in EX writing a register decode is about to read
    always_comb begin
        load_in_ex = valid_q && mem_read_q && (wr_addr_q != '0);
        dep_rs     = (wr_addr_q == rs_addr_i);
        dep_rt     = (wr_addr_q == rt_addr_i);
        hazard     = load_in_ex && id_valid_i && (dep_rs || dep_rt) && !stall_i;
    end

    // Destination register chosen at decode time so EX only carries one address
    always_comb begin
        wr_addr_next = reg_dst_i ? rd_addr_i : rt_addr_i;
    end

    // Valid bit and control fields: flush > stall > bubble > load
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (flush_i || (!stall_i && hazard)) begin
            valid_q      <= 1'b0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!stall_i) begin
            valid_q      <= id_valid_i;
            alu_ctrl_q   <= alu_ctrl_i;
            alu_src_q    <= alu_src_i;
            reg_write_q  <= reg_write_i;
            mem_read_q   <= mem_read_i;
            mem_write_q  <= mem_write_i;
            mem_to_reg_q <= mem_to_reg_i;
        end
    end

    // Operand data: on stall, capture the forwarded values so a result that is
    // only visible for one cycle is not lost while the stage is held
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else if (flush_i) begin
            rs_data_q <= rs_data_q;
            rt_data_q <= rt_data_q;
        end else if (stall_i) begin
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else if (!hazard) begin
            rs_data_q <= rs_data_i;
            rt_data_q <= rt_data_i;
        end
    end

    // Immediate and register numbers load only on a normal advance
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            wr_addr_q <= '0;
        end else if (!flush_i && !stall_i && !hazard) begin
            imm_q     <= imm_i;
            rs_addr_q <= rs_addr_i;
            rt_addr_q <= rt_addr_i;
            wr_addr_q <= wr_addr_next;
        end
    end

    // Execute-side outputs; side-effecting controls are masked by the valid bit
    always_comb begin
        src1_o       = fwd_rs;
        src2_o       = alu_src_q ? imm_q : fwd_rt;
        store_data_o = fwd_rt;
        alu_ctrl_o   = alu_ctrl_q;
        wr_addr_o    = wr_addr_q;
        ex_valid_o   = valid_q;
        reg_write_o  = valid_q && reg_write_q;
        mem_read_o   = valid_q && mem_read_q;
        mem_write_o  = valid_q && mem_write_q;
        mem_to_reg_o = valid_q && mem_to_reg_q;
        hazard_o     = hazard;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk_i  input  1  rising-edge clock; rst_i  input  1  asynchronous reset, active-low.
REQ-002 id_valid_i  input  1  decode stage holds a valid instruction.
REQ-003 stall_i  input  1  hold stage contents (downstream busy).
REQ-004 flush_i  input  1  kill stage contents (branch taken).
REQ-005 rs_data_i, rt_data_i, imm_i  input  32 each  register-file read data; sign-extended immediate.
REQ-006 rs_addr_i, rt_addr_i, rd_addr_i  input  5 each  source/destination register numbers.
REQ-007 alu_ctrl_i  input  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT).
REQ-008 alu_src_i, reg_dst_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  input  1 each  decoded controls.
REQ-009 exmem_reg_write_i  input  1; exmem_rd_i  input  5; exmem_result_i  input  32  EX/MEM forwarding source.
REQ-010 memwb_reg_write_i  input  1; memwb_rd_i  input  5; memwb_result_i  input  32  MEM/WB forwarding source.
REQ-011 src1_o, src2_o  output  32 each  ALU operands.
REQ-012 alu_ctrl_o  output  4  ALU operation code.
REQ-013 store_data_o  output  32  forwarded rt value for stores.
REQ-014 wr_addr_o  output  5  destination register (rd if reg_dst else rt).
REQ-015 reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o  output  1 each  registered controls, gated by valid.
REQ-016 ex_valid_o  output  1  EX stage holds a valid instruction.
REQ-017 hazard_o  output  1  load-use stall request to fetch/decode.

Function
REQ-018 Registered state SHALL be: valid, rs/rt data, imm, rs/rt addr, wr_addr, alu_ctrl, alu_src, reg_write, mem_read, mem_write, mem_to_reg.
REQ-019 Update priority each rising edge SHALL be: flush_i > stall_i > hazard bubble > normal load.
REQ-020 flush_i=1: valid and all control bits SHALL clear next cycle; data fields don't-care.
REQ-021 stall_i=1 (no flush): all fields SHALL hold, except rs/rt data which SHALL reload with the current forwarded operand values (REQ-025) so forwarded values survive the stall.
REQ-022 hazard_o=1 (no flush/stall): a bubble SHALL be loaded (valid=0, controls=0).
REQ-023 Normal load: all fields SHALL capture inputs; valid=id_valid_i; wr_addr = reg_dst_i ? rd_addr_i : rt_addr_i; latency 1 cycle ID->EX.
REQ-024 hazard_o SHALL be combinational = ex_valid & mem_read_q & wr_addr_q!=0 & id_valid_i & (wr_addr_q==rs_addr_i | wr_addr_q==rt_addr_i); forced 0 while stall_i=1.
REQ-025 Forwarded rs value SHALL be exmem_result_i if exmem_reg_write_i & exmem_rd_i!=0 & exmem_rd_i==rs_addr_q; else memwb_result_i if memwb_reg_write_i & memwb_rd_i!=0 & memwb_rd_i==rs_addr_q; else rs_data_q; rt identical with rt_addr_q.
REQ-026 EX/MEM SHALL take precedence over MEM/WB when both match.
REQ-027 Register 0 SHALL never be forwarded; rs/rt=0 reads yield stored data.
REQ-028 src1_o SHALL be forwarded rs; src2_o SHALL be imm_q if alu_src_q else forwarded rt; store_data_o SHALL always be forwarded rt.
REQ-029 reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o SHALL be 0 whenever ex_valid_o=0.
REQ-030 All outputs other than registered fields SHALL be combinational of state and forwarding inputs; no combinational path from id inputs to src*_o.

Reset
REQ-031 rst_i=0 SHALL asynchronously clear every register to 0: ex_valid_o=0, all controls 0, src1_o/src2_o/store_data_o=0 (absent forwarding match), alu_ctrl_o=0000, wr_addr_o=0, hazard_o=0.
REQ-032 Reset asserted mid-stall or mid-hazard SHALL discard the held instruction; first edge after release performs a normal load.

Verification
REQ-033 ADD r3=r1+r2, rs_data=5, rt_data=7, no forwarding -> next cycle src1_o=5, src2_o=7, alu_ctrl_o=0010, wr_addr_o=3, reg_write_o=1.
REQ-034 EX-stage rs=r4, exmem (write,rd=4,0x10) and memwb (write,rd=4,0x20) -> src1_o=0x10; exmem_rd=0 with memwb_rd=0 -> src1_o=rs_data_q.
REQ-035 EX holds lw to r8; ID holds sub using rt=r8 -> hazard_o=1, next cycle ex_valid_o=0 and all controls 0.
REQ-036 Instruction with rs=r5 stalled 2 cycles while memwb forwards r5=0xAB only in first stall cycle -> src1_o stays 0xAB in second cycle.
REQ-037 flush_i and stall_i both 1 -> next cycle ex_valid_o=0; rst_i pulsed low mid-stall -> all outputs 0 immediately.
